// File: rtl/counter_pkg.sv
// Shared types and helpers for the up/down counter family.
package counter_pkg;

    // Count direction as seen by the next-state logic.
    typedef enum logic {DIR_DOWN, DIR_UP} dir_e;

    // Widest counter supported; the helpers below work at this width.
    localparam int unsigned MAX_WIDTH = 32;

    // Limit a value to an upper bound; used to keep parallel loads inside the modulus.
    function automatic logic [MAX_WIDTH-1:0] clamp_u32(
        input logic [MAX_WIDTH-1:0] val,
        input logic [MAX_WIDTH-1:0] max_val
    );
        return (val > max_val) ? max_val : val;
    endfunction

endpackage

// File: rtl/updn_counter_next.sv
// Next-count and terminal-count logic for one enabled counting step.
// Purely combinational; the top level decides whether the step is taken.
module updn_counter_next
    import counter_pkg::*;
#(
    parameter int unsigned           WIDTH    = 8,
    parameter logic [WIDTH-1:0]      MAX_VAL  = {WIDTH{1'b1}},
    parameter bit                    SATURATE = 1'b0
) (
    input  logic [WIDTH-1:0] count,
    input  dir_e             dir,
    output logic [WIDTH-1:0] count_next,
    output logic             tc_next
);

    // Boundaries are detected by comparing against MAX_VAL and zero, so a
    // non-power-of-two modulus never relies on natural binary rollover.
    always_comb begin
        count_next = count;
        tc_next    = 1'b0;
        if (dir == DIR_UP) begin
            if (count >= MAX_VAL) begin
                tc_next    = 1'b1;
                count_next = SATURATE ? MAX_VAL : '0;
            end else begin
                count_next = count + WIDTH'(1);
            end
        end else begin
            if (count == '0) begin
                tc_next    = 1'b1;
                count_next = SATURATE ? '0 : MAX_VAL;
            end else begin
                count_next = count - WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/updn_counter.sv
// Parametrised up/down counter with load, clear, wrap/saturate mode,
// terminal-count pulse and sticky overflow flag. All outputs registered.
module updn_counter
    import counter_pkg::*;
#(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter bit               SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             ovf_sticky
);

    logic [WIDTH-1:0] step_count;
    logic             step_tc;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] out_d;
    logic             tc_d;

    updn_counter_next #(
        .WIDTH    (WIDTH),
        .MAX_VAL  (MAX_VAL),
        .SATURATE (SATURATE)
    ) u_next (
        .count      (out),
        .dir        (dir_e'(up_dn)),
        .count_next (step_count),
        .tc_next    (step_tc)
    );

    // Out-of-range load values are pulled back to MAX_VAL so the count
    // always stays inside the modulus.
    always_comb begin
        load_clamped = WIDTH'(clamp_u32(32'(load_val), 32'(MAX_VAL)));
    end

    // Priority mux: clear, then load, then count, otherwise hold.
    always_comb begin
        out_d = out;
        tc_d  = 1'b0;
        if (clr) begin
            out_d = '0;
        end else if (load) begin
            out_d = load_clamped;
        end else if (enable) begin
            out_d = step_count;
            tc_d  = step_tc;
        end
    end

    // State registers; a new tc on the same edge as ovf_clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            out        <= '0;
            tc         <= 1'b0;
            ovf_sticky <= 1'b0;
        end else begin
            out        <= out_d;
            tc         <= tc_d;
            ovf_sticky <= (ovf_sticky & ~ovf_clr) | tc_d;
        end
    end

endmodule

// File: tb/tb_updn_counter.sv
// Directed bench for updn_counter: WIDTH=4, MAX_VAL=9 in wrap and saturate mode.
module tb_updn_counter;

    typedef struct {
        logic       rst;
        logic       clr;
        logic       load;
        logic [3:0] lv;
        logic       en;
        logic       up;
        logic       oc;
        logic [3:0] e_out;
        logic       e_tc;
        logic       e_ovf;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Wrap-mode DUT signals
    logic       w_rst, w_clr, w_load, w_en, w_up, w_oc;
    logic [3:0] w_lv;
    logic [3:0] w_out;
    logic       w_tc, w_ovf;

    // Saturate-mode DUT signals
    logic       s_rst, s_clr, s_load, s_en, s_up, s_oc;
    logic [3:0] s_lv;
    logic [3:0] s_out;
    logic       s_tc, s_ovf;

    updn_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0)) dut_wrap (
        .clk        (clk),
        .rst        (w_rst),
        .enable     (w_en),
        .up_dn      (w_up),
        .clr        (w_clr),
        .load       (w_load),
        .load_val   (w_lv),
        .ovf_clr    (w_oc),
        .out        (w_out),
        .tc         (w_tc),
        .ovf_sticky (w_ovf)
    );

    updn_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b1)) dut_sat (
        .clk        (clk),
        .rst        (s_rst),
        .enable     (s_en),
        .up_dn      (s_up),
        .clr        (s_clr),
        .load       (s_load),
        .load_val   (s_lv),
        .ovf_clr    (s_oc),
        .out        (s_out),
        .tc         (s_tc),
        .ovf_sticky (s_ovf)
    );

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic r, input logic c, input logic l, input logic [3:0] lv,
        input logic e, input logic u, input logic o,
        input logic [3:0] eo, input logic et, input logic ev
    );
        vec_t t;
        t.rst = r; t.clr = c; t.load = l; t.lv = lv;
        t.en = e; t.up = u; t.oc = o;
        t.e_out = eo; t.e_tc = et; t.e_ovf = ev;
        return t;
    endfunction

    task automatic check(input string nm, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    endtask

    task automatic sat_step(input int idx, input logic r, input logic l, input logic [3:0] lv,
                            input logic e, input logic u,
                            input logic [3:0] eo, input logic et, input logic ev);
        s_rst = r; s_clr = 1'b0; s_load = l; s_lv = lv;
        s_en = e; s_up = u; s_oc = 1'b0;
        @(posedge clk); #1;
        check("sat_out", idx, 32'(s_out), 32'(eo));
        check("sat_tc",  idx, 32'(s_tc),  32'(et));
        check("sat_ovf", idx, 32'(s_ovf), 32'(ev));
    endtask

    initial begin
        w_rst = 1'b1; w_clr = 1'b0; w_load = 1'b0; w_lv = 4'd0;
        w_en = 1'b0; w_up = 1'b0; w_oc = 1'b0;
        s_rst = 1'b1; s_clr = 1'b0; s_load = 1'b0; s_lv = 4'd0;
        s_en = 1'b0; s_up = 1'b0; s_oc = 1'b0;

        //               rst clr ld lv    en up oc  out   tc ovf
        vecs.push_back(mk(1, 0, 0, 4'd0, 0, 0, 0, 4'd0, 0, 0));
        // Count up 12 cycles: 1..9, 0 (wrap, tc), 1, 2
        for (int i = 1; i <= 12; i++)
            vecs.push_back(mk(0, 0, 0, 4'd0, 1, 1, 0,
                              (i <= 9) ? 4'(i) : 4'(i - 10), (i == 10), (i >= 10)));
        // Load 3, then down 5: 2,1,0,9(tc),8
        vecs.push_back(mk(0, 0, 1, 4'd3, 0, 0, 0, 4'd3, 0, 1));
        vecs.push_back(mk(0, 0, 0, 4'd0, 1, 0, 0, 4'd2, 0, 1));
        vecs.push_back(mk(0, 0, 0, 4'd0, 1, 0, 0, 4'd1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 4'd0, 1, 0, 0, 4'd0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 4'd0, 1, 0, 0, 4'd9, 1, 1));
        vecs.push_back(mk(0, 0, 0, 4'd0, 1, 0, 0, 4'd8, 0, 1));
        // ovf_clr alone clears the flag, out holds
        vecs.push_back(mk(0, 0, 0, 4'd0, 0, 0, 1, 4'd8, 0, 0));
        // Up to 9, then wrap with ovf_clr on the same edge: set wins
        vecs.push_back(mk(0, 0, 0, 4'd0, 1, 1, 0, 4'd9, 0, 0));
        vecs.push_back(mk(0, 0, 0, 4'd0, 1, 1, 1, 4'd0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 4'd0, 0, 0, 1, 4'd0, 0, 0));
        // Priority: clr beats load and enable; then clamped load of 15
        vecs.push_back(mk(0, 1, 1, 4'd5, 1, 1, 0, 4'd0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 4'd15, 0, 0, 0, 4'd9, 0, 0));
        vecs.push_back(mk(0, 0, 0, 4'd0, 0, 1, 0, 4'd9, 0, 0));
        // Wrap sets ovf; clr leaves ovf set
        vecs.push_back(mk(0, 0, 0, 4'd0, 1, 1, 0, 4'd0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 4'd0, 1, 1, 0, 4'd1, 0, 1));
        vecs.push_back(mk(0, 1, 0, 4'd0, 1, 1, 0, 4'd0, 0, 1));
        // Direction change takes effect on the same edge
        vecs.push_back(mk(0, 0, 0, 4'd0, 1, 1, 0, 4'd1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 4'd0, 1, 0, 0, 4'd0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 4'd0, 1, 0, 0, 4'd9, 1, 1));
        // Reset mid-count at 7 with enable held, then resume
        vecs.push_back(mk(0, 0, 1, 4'd6, 0, 0, 0, 4'd6, 0, 1));
        vecs.push_back(mk(0, 0, 0, 4'd0, 1, 1, 0, 4'd7, 0, 1));
        vecs.push_back(mk(1, 0, 0, 4'd0, 1, 1, 0, 4'd0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 4'd0, 1, 1, 0, 4'd1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 4'd0, 1, 1, 0, 4'd2, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            w_rst = vecs[i].rst; w_clr = vecs[i].clr; w_load = vecs[i].load;
            w_lv = vecs[i].lv; w_en = vecs[i].en; w_up = vecs[i].up; w_oc = vecs[i].oc;
            @(posedge clk); #1;
            check("wrap_out", i, 32'(w_out), 32'(vecs[i].e_out));
            check("wrap_tc",  i, 32'(w_tc),  32'(vecs[i].e_tc));
            check("wrap_ovf", i, 32'(w_ovf), 32'(vecs[i].e_ovf));
        end
        w_en = 1'b0; w_load = 1'b0; w_clr = 1'b0; w_oc = 1'b0;

        // Saturate mode: pushing against a limit re-asserts tc every cycle
        sat_step(0, 1, 0, 4'd0, 0, 0, 4'd0, 0, 0);
        sat_step(1, 0, 1, 4'd8, 0, 0, 4'd8, 0, 0);
        sat_step(2, 0, 0, 4'd0, 1, 1, 4'd9, 0, 0);
        sat_step(3, 0, 0, 4'd0, 1, 1, 4'd9, 1, 1);
        sat_step(4, 0, 0, 4'd0, 1, 1, 4'd9, 1, 1);
        sat_step(5, 0, 0, 4'd0, 1, 0, 4'd8, 0, 1);
        sat_step(6, 0, 1, 4'd1, 0, 0, 4'd1, 0, 1);
        sat_step(7, 0, 0, 4'd0, 1, 0, 4'd0, 0, 1);
        sat_step(8, 0, 0, 4'd0, 1, 0, 4'd0, 1, 1);
        sat_step(9, 0, 0, 4'd0, 0, 0, 4'd0, 0, 1);
        sat_step(10, 0, 1, 4'd12, 0, 0, 4'd9, 0, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/updn_counter.md
# updn_counter

Parametrised up/down counter: successor to the 4-bit enable-only up counter. Adds configurable width and modulus, direction control, parallel load, synchronous clear, wrap or saturate mode, terminal-count pulse and sticky overflow flag. It serves as the general-purpose event/timer counter for datapath and testbench-facing blocks.

## Interface
- WIDTH, 8: counter width in bits; legal range 2..32.
- MAX_VAL, 2**WIDTH-1: highest count value (modulus = MAX_VAL+1); must satisfy 1 <= MAX_VAL <= 2**WIDTH-1.
- SATURATE, 0: 0 = wrap at the limits, 1 = hold at the limits.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- enable  input  1  count one step this cycle.
- up_dn  input  1  direction: 1 = up, 0 = down; sampled only when counting.
- clr  input  1  synchronous clear of `out` to 0.
- load  input  1  load `load_val` into `out`.
- load_val  input  WIDTH  parallel load value.
- ovf_clr  input  1  clear `ovf_sticky`.
- out  output  WIDTH  current count.
- tc  output  1  terminal-count pulse, 1 cycle.
- ovf_sticky  output  1  set by any `tc` event; held until cleared.

## Operation
- Per-edge priority: `rst` > `clr` > `load` > `enable` > hold.
- On `rst`: `out`=0, `tc`=0, `ovf_sticky`=0.
- On `clr`: `out`=0, `tc`=0. `ovf_sticky` is unaffected unless `ovf_clr` is also asserted.
- On `load`:
  - `out` = `load_val`; if `load_val` > MAX_VAL, `out` = MAX_VAL (clamped).
  - `tc`=0.
- Counting up (`enable`=1, `up_dn`=1):
  - `out` < MAX_VAL: `out`+1.
  - `out` == MAX_VAL: `tc`=1, and `out` becomes 0 (wrap) or stays MAX_VAL (saturate).
- Counting down (`enable`=1, `up_dn`=0):
  - `out` > 0: `out`-1.
  - `out` == 0: `tc`=1, and `out` becomes MAX_VAL (wrap) or stays 0 (saturate).
- Saturate mode: `tc` re-asserts every enabled cycle while pushing against a limit.
- Hold (`enable`=0, no clr/load): `out` unchanged, `tc`=0.
- `ovf_sticky`:
  - Next value = (`ovf_sticky` & ~`ovf_clr`) | tc_next.
  - Simultaneous set and clear: set wins.
- Arithmetic is done in WIDTH bits. The non-power-of-two modulus is handled by the compare against MAX_VAL, never by natural rollover.
- Direction change mid-count takes effect on the same edge; no extra latency.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- Latency: one edge from input sample to new `out`. `tc` and `ovf_sticky` update on the same edge as the `out` change that caused them.
- `tc` is high exactly one cycle per boundary event (wrap mode).
- Reset mid-operation overrides everything on that edge. The first count after `rst` deasserts occurs on the next enabled edge.

## Structure
- Package `counter_pkg`:
  - `typedef enum logic {DIR_DOWN, DIR_UP} dir_e;`
  - Shared localparam helpers, e.g. the clamp function.
- One combinational sub-module, `updn_counter_next`: computes next count and tc_next from current count, direction and the mode parameters.
- Top level holds the registers, the priority mux and the sticky flag.

## Test plan
- WIDTH=4, MAX_VAL=9, SATURATE=0; rst then enable, up for 12 cycles -> `out` 0..9,0,1,2; `tc`=1 only on the cycle `out` shows 0 after 9; `ovf_sticky`=1 afterwards.
- Same config, load 3 then down for 5 cycles -> 3,2,1,0,9,8; `tc` pulses when `out` goes 0 -> 9.
- SATURATE=1, MAX_VAL=9: load 8, up 3 cycles -> 9,9,9 with `tc`=0,1,1; then down 1 cycle -> 8 with `tc`=0.
- Priority: clr=1, load=1 (`load_val`=5), enable=1 in the same cycle -> `out`=0. Next cycle load=1 with `load_val`=15 -> `out`=9 (clamped).
- `ovf_clr` asserted on the same edge as a wrap -> `ovf_sticky` stays 1; `ovf_clr` alone next cycle -> 0.
- rst asserted while counting at `out`=7 with enable held -> next edge `out`=0, `tc`=0, `ovf_sticky`=0; count resumes 1,2,... after rst drops.
